core_pll_reconfig_seq: RTL and testbench
========================================

Name: core_pll_reconfig_seq

Overview:
- Avalon-MM master that retunes the core PLL at runtime through the PLL reconfiguration controller's management port.
- On request, writes one of two stored M/N/C0/C1 counter profiles, triggers the reconfiguration, polls for completion, then qualifies PLL lock.
- Sits in the management clock domain beside the core PLL and its reconfig controller.
- Lets the LTC2123 capture path switch sample-clock plans without a full FPGA reconfiguration.

Parameters:
- P0_N, 18'h10000, profile 0 N counter word {odd[17], bypass[16], hi[15:8], lo[7:0]} (N bypassed)
- P0_M, 18'h00202, profile 0 M counter word (hi=2, lo=2)
- P0_C0, 18'h00101, profile 0 C0 word (hi=1, lo=1)
- P0_C1, 18'h00202, profile 0 C1 word (hi=2, lo=2)
- P1_N, 18'h10000, profile 1 N word
- P1_M, 18'h00202, profile 1 M word
- P1_C0, 18'h00202, profile 1 C0 word
- P1_C1, 18'h00404, profile 1 C1 word
- POLL_MAX, 1024, maximum status-register reads before timeout
- LOCK_SETTLE, 256, consecutive locked cycles required
- LOCK_TIMEOUT, 65536, maximum cycles in lock wait

Ports:
- clk  in  1  management clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- profile_sel  in  1  profile to load; captured with start
- busy  out  1  high from accepted start until DONE or ERR exits
- done  out  1  one-cycle pulse on success
- err  out  1  sticky error flag; cleared by next accepted start
- err_code  out  2  0 none, 1 poll timeout, 2 lock timeout, 3 readback mismatch
- active_profile  out  1  last successfully loaded profile
- mgmt_address  out  6  reconfig register address
- mgmt_read  out  1  read strobe
- mgmt_write  out  1  write strobe
- mgmt_writedata  out  32  write data
- mgmt_readdata  in  32  read data
- mgmt_waitrequest  in  1  slave stall
- pll_locked  in  1  PLL locked, asynchronous; double-flop synchronised internally

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-operation aborts immediately and deasserts strobes; the caller re-issues start.
- Bus rules:
  - A transaction holds address, strobe and data constant until the first cycle with mgmt_waitrequest=0, then drops the strobe on the next cycle.
  - Read data is captured in the cycle with mgmt_read=1 and mgmt_waitrequest=0.
  - mgmt_read and mgmt_write are never both high.
  - There is at least one idle cycle between transactions.
- Register map:
  - mode = 0x00; write 1 selects polling mode
  - status = 0x01; bit0 = 1 means done
  - start = 0x02; write 0
  - N = 0x03
  - M = 0x04
  - C = 0x05; data[22:18] = counter index, data[17:0] = word
- FSM:
  - IDLE: on start, capture profile_sel, clear err/err_code, set busy, go to MODE.
  - MODE: write 0x00 = 1.
  - WR_N: write 0x03 = N word.
  - WR_M: write 0x04 = M word.
  - WR_C0: write 0x05 = {index 0, C0}.
  - WR_C1: write 0x05 = {index 1, C1}.
  - START: write 0x02 = 0.
  - POLL: read 0x01.
    - bit0 = 1 -> LOCK_WAIT.
    - bit0 = 0 -> reread; increment poll count.
    - Poll count reaching POLL_MAX -> ERR with code 1.
  - LOCK_WAIT: increment timer each cycle.
    - Settle counter counts consecutive synchronised pll_locked=1 cycles and resets to 0 on any low cycle.
    - Settle reaching LOCK_SETTLE -> DONE.
    - Timer reaching LOCK_TIMEOUT -> ERR with code 2.
  - DONE: pulse done, set active_profile, clear busy -> IDLE.
  - ERR: set err and err_code, clear busy, active_profile unchanged -> IDLE.
- Unused writedata bits are zero.
- start while busy is ignored and not queued.
- start and reset together: reset wins.
- Counters saturate and never wrap.

Optional Feature:
- Macro: PLL_RECONFIG_READBACK_EN.
- Defined:
  - After WR_C1, insert RB_N (read 0x03) and RB_M (read 0x04) before START.
  - Compare readdata[17:0] to the written word.
  - Any mismatch -> ERR with code 3, no START issued.
- Undefined: those states are absent; WR_C1 goes directly to START; code 3 is never produced.

Test Plan:
- Responsive slave, waitrequest always 0, profile_sel=1, locked high -> writes in order 0x00=1, 0x03=0x10000, 0x04=0x00202, 0x05=0x000202, 0x05=0x040404, 0x02=0; status reads 1; done pulses after 256 locked cycles; active_profile=1.
- waitrequest held high 5 cycles per transaction -> strobe/address/data stable throughout; same write sequence and result.
- Status bit0 never set -> exactly 1024 status reads, then err=1, err_code=1, busy=0, active_profile unchanged.
- pll_locked toggling low every 200 cycles -> err_code=2 after 65536 LOCK_WAIT cycles; a second start clears err and succeeds with locked steady.
- rst_n low during WR_M under stall -> strobes drop asynchronously, outputs 0; start while busy ignored (one sequence only).
- With PLL_RECONFIG_READBACK_EN, slave returns 0x00203 for M -> err_code=3, no write to 0x02.

Source files
------------

// File: rtl/core_pll_reconfig_seq.sv
// core_pll_reconfig_seq: Avalon-MM master that retunes the core PLL through the
// reconfiguration controller's management port. On start it writes one of two
// stored N/M/C0/C1 profiles, triggers the reconfiguration, polls the status
// register for completion and then qualifies PLL lock.
// Optional build macro: PLL_RECONFIG_READBACK_EN reads N and M back after the
// counter writes and aborts with error code 3 on a mismatch.
module core_pll_reconfig_seq #(
    parameter logic [17:0] P0_N         = 18'h10000,
    parameter logic [17:0] P0_M         = 18'h00202,
    parameter logic [17:0] P0_C0        = 18'h00101,
    parameter logic [17:0] P0_C1        = 18'h00202,
    parameter logic [17:0] P1_N         = 18'h10000,
    parameter logic [17:0] P1_M         = 18'h00202,
    parameter logic [17:0] P1_C0        = 18'h00202,
    parameter logic [17:0] P1_C1        = 18'h00404,
    parameter int          POLL_MAX     = 1024,
    parameter int          LOCK_SETTLE  = 256,
    parameter int          LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        profile_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        active_profile,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_SETTLE + 1);

    localparam logic [PW-1:0] POLL_MAX_C     = PW'(POLL_MAX);
    localparam logic [TW-1:0] LOCK_TIMEOUT_C = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] LOCK_SETTLE_C  = SW'(LOCK_SETTLE);

    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_MODE  = 4'd1,
        S_WR_N  = 4'd2,
        S_WR_M  = 4'd3,
        S_WR_C0 = 4'd4,
        S_WR_C1 = 4'd5,
`ifdef PLL_RECONFIG_READBACK_EN
        S_RB_N  = 4'd6,
        S_RB_M  = 4'd7,
`endif
        S_START = 4'd8,
        S_POLL  = 4'd9,
        S_LOCK  = 4'd10,
        S_DONE  = 4'd11,
        S_ERR   = 4'd12
    } state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [1:0]    fail_q, fail_d;
    logic          active_q, active_d;
    logic          prof_q, prof_d;
    logic [5:0]    addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          lock_meta_q, lock_sync_q;

    logic [17:0]   n_word_s, m_word_s, c0_word_s, c1_word_s;
    logic          cmd_bus_s, cmd_rd_s;
    logic [5:0]    cmd_addr_s;
    logic [31:0]   cmd_data_s;
    logic [PW-1:0] poll_inc_s;
    logic [TW-1:0] timer_inc_s;
    logic [SW-1:0] settle_inc_s;
    logic          unused_s;

    // Upper read-data bits carry nothing this sequencer looks at.
    assign unused_s = ^mgmt_readdata[31:1];

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Select the counter words of the captured profile and saturating increments.
    always_comb begin
        n_word_s  = prof_q ? P1_N  : P0_N;
        m_word_s  = prof_q ? P1_M  : P0_M;
        c0_word_s = prof_q ? P1_C0 : P0_C0;
        c1_word_s = prof_q ? P1_C1 : P0_C1;
        poll_inc_s   = (poll_q == POLL_MAX_C) ? poll_q : poll_q + 1'b1;
        timer_inc_s  = (timer_q == LOCK_TIMEOUT_C) ? timer_q : timer_q + 1'b1;
        if (!lock_sync_q) begin
            settle_inc_s = '0;
        end else if (settle_q == LOCK_SETTLE_C) begin
            settle_inc_s = settle_q;
        end else begin
            settle_inc_s = settle_q + 1'b1;
        end
    end

    // Bus command (address, direction, data) issued by each transaction state.
    always_comb begin
        cmd_bus_s  = 1'b0;
        cmd_rd_s   = 1'b0;
        cmd_addr_s = 6'h00;
        cmd_data_s = 32'h0000_0000;
        case (state_q)
            S_MODE:  begin cmd_bus_s = 1'b1; cmd_addr_s = ADDR_MODE;  cmd_data_s = 32'h0000_0001; end
            S_WR_N:  begin cmd_bus_s = 1'b1; cmd_addr_s = ADDR_N;     cmd_data_s = {14'h0000, n_word_s}; end
            S_WR_M:  begin cmd_bus_s = 1'b1; cmd_addr_s = ADDR_M;     cmd_data_s = {14'h0000, m_word_s}; end
            S_WR_C0: begin cmd_bus_s = 1'b1; cmd_addr_s = ADDR_C;     cmd_data_s = {9'h000, 5'd0, c0_word_s}; end
            S_WR_C1: begin cmd_bus_s = 1'b1; cmd_addr_s = ADDR_C;     cmd_data_s = {9'h000, 5'd1, c1_word_s}; end
`ifdef PLL_RECONFIG_READBACK_EN
            S_RB_N:  begin cmd_bus_s = 1'b1; cmd_rd_s = 1'b1; cmd_addr_s = ADDR_N; end
            S_RB_M:  begin cmd_bus_s = 1'b1; cmd_rd_s = 1'b1; cmd_addr_s = ADDR_M; end
`endif
            S_START: begin cmd_bus_s = 1'b1; cmd_addr_s = ADDR_START; cmd_data_s = 32'h0000_0000; end
            S_POLL:  begin cmd_bus_s = 1'b1; cmd_rd_s = 1'b1; cmd_addr_s = ADDR_STATUS; end
            default: begin cmd_bus_s = 1'b0; end
        endcase
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        fail_d     = fail_q;
        active_d   = active_q;
        prof_d     = prof_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        poll_d     = poll_q;
        timer_d    = timer_q;
        settle_d   = settle_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prof_d     = profile_sel;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    fail_d     = 2'd0;
                    busy_d     = 1'b1;
                    poll_d     = '0;
                    timer_d    = '0;
                    settle_d   = '0;
                    state_d    = S_MODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                timer_d  = timer_inc_s;
                settle_d = settle_inc_s;
                if (settle_inc_s == LOCK_SETTLE_C) begin
                    state_d = S_DONE;
                end else if (timer_inc_s == LOCK_TIMEOUT_C) begin
                    fail_d  = 2'd2;
                    state_d = S_ERR;
                end else begin
                    state_d = S_LOCK;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                active_d = prof_q;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                err_d      = 1'b1;
                err_code_d = fail_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                if (!cmd_bus_s) begin
                    // Unreachable encoding: park safely with the bus idle.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!(rd_q || wr_q)) begin
                    // Launch; strobe was low last cycle so the idle gap is kept.
                    rd_d    = cmd_rd_s;
                    wr_d    = !cmd_rd_s;
                    addr_d  = cmd_addr_s;
                    wdata_d = cmd_rd_s ? 32'h0000_0000 : cmd_data_s;
                end else if (!mgmt_waitrequest) begin
                    // Accepted this cycle: drop the strobe and move on.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = 6'h00;
                    wdata_d = 32'h0000_0000;
                    case (state_q)
                        S_MODE:  state_d = S_WR_N;
                        S_WR_N:  state_d = S_WR_M;
                        S_WR_M:  state_d = S_WR_C0;
                        S_WR_C0: state_d = S_WR_C1;
`ifdef PLL_RECONFIG_READBACK_EN
                        S_WR_C1: state_d = S_RB_N;
                        S_RB_N: begin
                            if (mgmt_readdata[17:0] != n_word_s) begin
                                fail_d  = 2'd3;
                                state_d = S_ERR;
                            end else begin
                                state_d = S_RB_M;
                            end
                        end
                        S_RB_M: begin
                            if (mgmt_readdata[17:0] != m_word_s) begin
                                fail_d  = 2'd3;
                                state_d = S_ERR;
                            end else begin
                                state_d = S_START;
                            end
                        end
`else
                        S_WR_C1: state_d = S_START;
`endif
                        S_START: begin
                            poll_d  = '0;
                            state_d = S_POLL;
                        end
                        S_POLL: begin
                            if (mgmt_readdata[0]) begin
                                timer_d  = '0;
                                settle_d = '0;
                                state_d  = S_LOCK;
                            end else begin
                                poll_d = poll_inc_s;
                                if (poll_inc_s == POLL_MAX_C) begin
                                    fail_d  = 2'd1;
                                    state_d = S_ERR;
                                end else begin
                                    state_d = S_POLL;
                                end
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    // Slave stalling: hold address, strobe and data.
                    state_d = state_q;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            fail_q     <= 2'd0;
            active_q   <= 1'b0;
            prof_q     <= 1'b0;
            addr_q     <= 6'h00;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            poll_q     <= '0;
            timer_q    <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            fail_q     <= fail_d;
            active_q   <= active_d;
            prof_q     <= prof_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            poll_q     <= poll_d;
            timer_q    <= timer_d;
            settle_q   <= settle_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign active_profile = active_q;
    assign mgmt_address   = addr_q;
    assign mgmt_read      = rd_q;
    assign mgmt_write     = wr_q;
    assign mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_core_pll_reconfig_seq.sv
// Directed bench for core_pll_reconfig_seq with a small Avalon slave model.
module tb_core_pll_reconfig_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, profile_sel;
    logic        busy, done, err, active_profile;
    logic [1:0]  err_code;
    logic [5:0]  mgmt_address;
    logic        mgmt_read, mgmt_write, mgmt_waitrequest, pll_locked;
    logic [31:0] mgmt_writedata, mgmt_readdata;

    int n_tests = 0;
    int n_fail  = 0;

    // slave / environment controls (driven by the initial block)
    logic        stall_en, status_val, tog_en;
    logic [31:0] rb_mask;

    // monitor state (driven by the monitor only)
    int          wait_cnt, wr_n, status_reads, viol, done_cnt, tog_cnt;
    logic        tog_lvl, prev_stall, prev_cmp, prev_rd, prev_wr;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    logic [5:0]  wa_log [0:255];
    logic [31:0] wd_log [0:255];
    logic [31:0] slave_regs [0:63];

    always #5 clk = ~clk;

    core_pll_reconfig_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .profile_sel(profile_sel),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .active_profile(active_profile), .mgmt_address(mgmt_address),
        .mgmt_read(mgmt_read), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    assign pll_locked = tog_en ? tog_lvl : 1'b1;

    // Slave response: optional 5-cycle stall, status bit, register readback.
    always_comb begin
        mgmt_waitrequest = stall_en && (mgmt_read || mgmt_write) && (wait_cnt < 5);
        if (mgmt_address == 6'h01) mgmt_readdata = {31'h0, status_val};
        else if (mgmt_address == 6'h04) mgmt_readdata = slave_regs[4] ^ rb_mask;
        else mgmt_readdata = slave_regs[mgmt_address];
    end

    // Lock input that drops for two cycles out of every 200.
    always @(negedge clk) begin
        if (tog_en) begin
            tog_cnt <= tog_cnt + 1;
            tog_lvl <= ((tog_cnt % 200) >= 2);
        end else begin
            tog_cnt <= 0;
            tog_lvl <= 1'b1;
        end
    end

    // Bus monitor: logs writes, counts status reads, flags protocol violations.
    always @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt   <= 0;
            prev_stall <= 1'b0;
            prev_cmp   <= 1'b0;
            for (int i = 0; i < 64; i++) slave_regs[i] <= 32'h0;
        end else begin
            if (mgmt_read && mgmt_write) viol <= viol + 1;
            if (prev_stall && (mgmt_address != prev_addr || mgmt_writedata != prev_data ||
                               mgmt_read != prev_rd || mgmt_write != prev_wr)) viol <= viol + 1;
            if (prev_cmp && (mgmt_read || mgmt_write)) viol <= viol + 1;
            prev_stall <= (mgmt_read || mgmt_write) && mgmt_waitrequest;
            prev_cmp   <= (mgmt_read || mgmt_write) && !mgmt_waitrequest;
            prev_addr  <= mgmt_address;
            prev_data  <= mgmt_writedata;
            prev_rd    <= mgmt_read;
            prev_wr    <= mgmt_write;
            if ((mgmt_read || mgmt_write) && mgmt_waitrequest) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (mgmt_write && !mgmt_waitrequest) begin
                wa_log[wr_n[7:0]] <= mgmt_address;
                wd_log[wr_n[7:0]] <= mgmt_writedata;
                wr_n <= wr_n + 1;
                slave_regs[mgmt_address] <= mgmt_writedata;
            end
            if (mgmt_read && !mgmt_waitrequest && mgmt_address == 6'h01) status_reads <= status_reads + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        wr_n = 0; status_reads = 0; viol = 0; done_cnt = 0;
    end

    // Expected {address, data} of write number i for profile sel.
    function automatic logic [37:0] exp_wr(input int i, input logic sel);
        case (i)
            0: exp_wr = {6'h00, 32'h0000_0001};
            1: exp_wr = {6'h03, 32'h0001_0000};
            2: exp_wr = {6'h04, 32'h0000_0202};
            3: exp_wr = sel ? {6'h05, 32'h0000_0202} : {6'h05, 32'h0000_0101};
            4: exp_wr = sel ? {6'h05, 32'h0004_0404} : {6'h05, 32'h0004_0202};
            5: exp_wr = {6'h02, 32'h0000_0000};
            default: exp_wr = 38'h0;
        endcase
    endfunction

    task automatic do_start(input logic sel);
        @(negedge clk); start = 1'b1; profile_sel = sel;
        @(negedge clk); start = 1'b0;
    endtask

    // Waits for done or err; cyc = negedges since the last accepted status read.
    task automatic wait_end(input int budget, output int cyc, output bit hit);
        int n;
        n = 0; cyc = 0; hit = 1'b0;
        while (n < budget && !hit) begin
            @(negedge clk);
            n++; cyc++;
            if (mgmt_read && !mgmt_waitrequest && mgmt_address == 6'h01) cyc = 0;
            if (done || err) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({busy, done, err, err_code, active_profile, mgmt_address, mgmt_read, mgmt_write, mgmt_writedata} !== 45'h0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b err=%b code=%0d act=%b rd=%b wr=%b addr=%h, required all 0",
                               busy, err, err_code, active_profile, mgmt_read, mgmt_write, mgmt_address);
        end
    endtask

    task automatic test_sequence(input string name, input logic stall, input logic sel);
        int base, dbase, cyc; bit hit;
        stall_en = stall; status_val = 1'b1;
        base = wr_n; dbase = done_cnt;
        do_start(sel);
        wait_end(5000, cyc, hit);
        n_tests++;
        if (hit !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL %s_done: hit=%b done=%b required done=1", name, hit, done); end
        n_tests++;
        if (cyc != 258) begin n_fail++; $display("FAIL %s_lock_latency: got %0d cycles required 258", name, cyc); end
        n_tests++;
        if ({busy, err, err_code, active_profile} !== {1'b0, 1'b0, 2'd0, sel}) begin
            n_fail++; $display("FAIL %s_status: busy=%b err=%b code=%0d act=%b required 0 0 0 %b", name, busy, err, err_code, active_profile, sel);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (wr_n - base != 6) begin n_fail++; $display("FAIL %s_write_count: got %0d required 6", name, wr_n - base); end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({wa_log[base + i], wd_log[base + i]} !== exp_wr(i, sel)) begin
                n_fail++; $display("FAIL %s_write[%0d]: got %h=%h required %h", name, i, wa_log[base + i], wd_log[base + i], exp_wr(i, sel));
            end
        end
        n_tests++;
        if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt - dbase); end
        n_tests++;
        if (viol != 0) begin n_fail++; $display("FAIL %s_bus_protocol: got %0d violations required 0", name, viol); end
        stall_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base, dbase, cyc; bit hit;
        base = wr_n; dbase = done_cnt; status_val = 1'b1;
        do_start(1'b1);
        repeat (4) @(negedge clk);
        do_start(1'b0);
        wait_end(5000, cyc, hit);
        repeat (40) @(negedge clk);
        n_tests++;
        if (wr_n - base != 6 || done_cnt - dbase != 1 || active_profile !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_ignored: writes=%0d dones=%0d act=%b required 6 1 1", wr_n - base, done_cnt - dbase, active_profile);
        end
    endtask

    task automatic test_poll_timeout();
        int sbase, cyc; bit hit;
        status_val = 1'b0; sbase = status_reads;
        do_start(1'b0);
        wait_end(10000, cyc, hit);
        n_tests++;
        if (hit !== 1'b1 || status_reads - sbase != 1024) begin
            n_fail++; $display("FAIL poll_count: hit=%b reads=%0d required 1024", hit, status_reads - sbase);
        end
        n_tests++;
        if ({err, err_code, busy, done, active_profile} !== {1'b1, 2'd1, 1'b0, 1'b0, 1'b1} || cyc != 2) begin
            n_fail++; $display("FAIL poll_timeout_status: err=%b code=%0d busy=%b act=%b cyc=%0d required 1 1 0 1 2", err, err_code, busy, active_profile, cyc);
        end
        status_val = 1'b1;
    endtask

    task automatic test_lock_timeout();
        int cyc; bit hit;
        status_val = 1'b1; tog_en = 1'b1;
        do_start(1'b0);
        wait_end(70000, cyc, hit);
        n_tests++;
        if (hit !== 1'b1 || cyc != 65538) begin n_fail++; $display("FAIL lock_timeout_latency: hit=%b cyc=%0d required 65538", hit, cyc); end
        n_tests++;
        if ({err, err_code, busy, active_profile} !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL lock_timeout_status: err=%b code=%0d busy=%b act=%b required 1 2 0 1", err, err_code, busy, active_profile);
        end
        tog_en = 1'b0;
        repeat (4) @(negedge clk);
        do_start(1'b0);
        n_tests++;
        if ({err, err_code, busy} !== {1'b0, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL err_clear_on_start: err=%b code=%0d busy=%b required 0 0 1", err, err_code, busy);
        end
        wait_end(5000, cyc, hit);
        n_tests++;
        if (hit !== 1'b1 || done !== 1'b1 || active_profile !== 1'b0) begin
            n_fail++; $display("FAIL retry_success: done=%b act=%b required 1 0", done, active_profile);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit seen;
        stall_en = 1'b1; status_val = 1'b1;
        do_start(1'b1);
        n = 0; seen = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge clk); n++;
            if (mgmt_write && mgmt_address == 6'h04 && mgmt_waitrequest) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid_reach_wr_m: seen=0 required 1"); end
        #2 rst_n = 1'b0; start = 1'b1;
        #1;
        n_tests++;
        if ({busy, err, done, active_profile, mgmt_read, mgmt_write, mgmt_address, mgmt_writedata} !== 42'h0) begin
            n_fail++; $display("FAIL reset_mid_async: busy=%b act=%b rd=%b wr=%b addr=%h data=%h required all 0",
                               busy, active_profile, mgmt_read, mgmt_write, mgmt_address, mgmt_writedata);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || mgmt_write !== 1'b0) begin n_fail++; $display("FAIL reset_wins_over_start: busy=%b wr=%b required 0 0", busy, mgmt_write); end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        stall_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

`ifdef PLL_RECONFIG_READBACK_EN
    task automatic test_readback();
        int base, cyc; bit hit;
        rb_mask = 32'h0000_0001; base = wr_n;
        do_start(1'b1);
        wait_end(5000, cyc, hit);
        repeat (5) @(negedge clk);
        n_tests++;
        if ({hit, err, err_code, active_profile} !== {1'b1, 1'b1, 2'd3, 1'b0} || wr_n - base != 5) begin
            n_fail++; $display("FAIL readback_mismatch: err=%b code=%0d act=%b writes=%0d required 1 3 0 5", err, err_code, active_profile, wr_n - base);
        end
        rb_mask = 32'h0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; profile_sel = 1'b0;
        stall_en = 1'b0; status_val = 1'b1; tog_en = 1'b0; rb_mask = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_sequence("basic", 1'b0, 1'b1);
        test_sequence("stall", 1'b1, 1'b1);
        test_back_to_back();
        test_poll_timeout();
        test_lock_timeout();
        test_reset_mid();
`ifdef PLL_RECONFIG_READBACK_EN
        test_readback();
`endif
        test_sequence("after_reset", 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
